// File: rtl/bitstream_aligner.sv
// bitstream_aligner: 64-bit MSB-aligned bit buffer feeding the CAVLC syntax
// decoders. It accepts 32-bit stream words and consumes 0..16 bits per cycle
// from a left-aligned 16-bit window.
module bitstream_aligner (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [31:0] InData,
    input  logic        InValid,
    output logic        InReady,
    input  logic        Flush,
    input  logic        ShiftEn,
    input  logic [4:0]  Shift,
    output logic [15:0] Window,
    output logic        WindowValid,
    output logic [6:0]  Level,
    output logic        ShiftErr
);

    // Buffer state: bufReg[63] is the next stream bit, cntReg bits are valid.
    logic [63:0] bufReg;
    logic [63:0] bufNext;
    logic [6:0]  cntReg;
    logic [6:0]  cntNext;
    logic        errReg;
    logic        errNext;

    logic        load;
    logic        legal;
    logic        cons;
    logic [6:0]  shiftAmt;
    logic [6:0]  remCnt;
    logic [63:0] placedWord;

    // Room for a word whenever at most 32 bits remain; never during a flush.
    assign InReady = (cntReg <= 7'd32) && !Flush;
    assign load    = InValid && InReady;

    // A shift is legal if it fits the window and the bits actually buffered.
    assign legal    = (Shift <= 5'd16) && ({2'b00, Shift} <= cntReg);
    assign cons     = ShiftEn && legal && !Flush;
    assign shiftAmt = cons ? {2'b00, Shift} : 7'd0;
    assign remCnt   = cntReg - shiftAmt;

    // New word lands right behind the bits left after this cycle's consume.
    // remCnt <= 32 whenever load is high, so the whole word always fits.
    assign placedWord = {InData, 32'h0000_0000} >> remCnt;

    // Next-state computation: consume first, then append, flush overrides all.
    always_comb begin
        bufNext = bufReg << shiftAmt;
        cntNext = remCnt;
        errNext = errReg;
        if (load) begin
            bufNext = bufNext | placedWord;
            cntNext = remCnt + 7'd32;
        end
        if (ShiftEn && !legal) begin
            errNext = 1'b1;
        end
        if (Flush) begin
            bufNext = 64'd0;
            cntNext = 7'd0;
            errNext = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            bufReg <= 64'd0;
            cntReg <= 7'd0;
            errReg <= 1'b0;
        end else begin
            bufReg <= bufNext;
            cntReg <= cntNext;
            errReg <= errNext;
        end
    end

    // Outputs come straight from registers; unused window bits are already 0.
    assign Window      = bufReg[63:48];
    assign WindowValid = (cntReg >= 7'd16);
    assign Level       = cntReg;
    assign ShiftErr    = errReg;

endmodule
